// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and helper functions for the exhaustive BIST controller
//
// Purpose:
//   FSM state encoding plus the Gray-code and MISR next-state helpers used by
//   exhaustive_bist_ctrl and bist_misr. Helpers work on HELPER_W-bit vectors;
//   callers zero-extend their operands and truncate the result.
// Contents:
//   bist_state_t  IDLE=0, RUN=1, DONE=2
//   bin2gray(x)   x ^ (x >> 1)
//   misr_next(sig, resp, poly[, w])  one MISR step for a w-bit register
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_t;

  localparam int unsigned HELPER_W = 32;

  function automatic logic [HELPER_W-1:0] bin2gray(input logic [HELPER_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Shift left, fold the outgoing MSB back through POLY, then XOR in the response.
  // w is the live register width; bits above it are masked off.
  function automatic logic [HELPER_W-1:0] misr_next(
    input logic [HELPER_W-1:0] sig,
    input logic [HELPER_W-1:0] resp,
    input logic [HELPER_W-1:0] poly,
    input int unsigned         w = HELPER_W
  );
    logic [HELPER_W-1:0] w_mask;
    logic [HELPER_W-1:0] w_nxt;
    w_mask = (w >= HELPER_W) ? '1 : ((HELPER_W'(1) << w) - HELPER_W'(1));
    w_nxt  = (sig << 1) ^ resp;
    if (sig[w-1]) begin
      w_nxt = w_nxt ^ poly;
    end
    return w_nxt & w_mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - multiple-input signature register for the exhaustive BIST controller
//
// Purpose:
//   Holds the signature. load has priority over en; with neither asserted the
//   signature is frozen.
// Ports:
//   Clk    in   1      rising-edge clock
//   Rst_n  in   1      asynchronous active-low reset, clears the signature
//   load   in   1      load seed
//   seed   in   SIG_W  value loaded on load
//   en     in   1      advance the MISR by one step using resp
//   resp   in   SIG_W  zero-extended CUT response
//   sig    out  SIG_W  current signature
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h002D)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic [SIG_W-1:0] resp,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sig <= '0;
    end else if (load) begin
      r_sig <= seed;
    end else if (en) begin
      r_sig <= SIG_W'(misr_next(HELPER_W'(r_sig), HELPER_W'(resp), HELPER_W'(POLY), SIG_W));
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/exhaustive_bist_ctrl.sv
// rtl/exhaustive_bist_ctrl.sv - exhaustive pattern sequencer with MISR compaction and pass/fail
//
// Purpose:
//   Drives all 2^N_IN patterns (binary or Gray order) into a combinational CUT,
//   holding each for HOLD cycles, compacts the responses into a MISR and
//   compares the final signature against GOLDEN.
// Ports:
//   Clk        in   1      rising-edge clock
//   Rst_n      in   1      asynchronous active-low reset
//   Start      in   1      begin a run (accepted in IDLE/DONE only)
//   Abort      in   1      abandon the run, back to IDLE without Done
//   GrayMode   in   1      0 = binary order, 1 = Gray order; latched on Start
//   Pattern    out  N_IN   stimulus to the CUT
//   CutResp    in   N_OUT  CUT response, combinational from Pattern
//   Busy       out  1      run in progress
//   Done       out  1      run complete, sticky until next Start
//   Pass       out  1      Signature == GOLDEN, valid while Done
//   Signature  out  SIG_W  current MISR value
module exhaustive_bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned      N_IN   = 5,
  parameter int unsigned      N_OUT  = 2,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(16'h002D),
  parameter logic [SIG_W-1:0] SEED   = '0,
  parameter logic [SIG_W-1:0] GOLDEN = '0,
  parameter int unsigned      HOLD   = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic             GrayMode,
  output logic [N_IN-1:0]  Pattern,
  input  logic [N_OUT-1:0] CutResp,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [SIG_W-1:0] Signature
);

  localparam int unsigned       HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  bist_state_t      r_state;
  logic [N_IN:0]    r_idx;
  logic [HOLD_W-1:0] r_hold;
  logic             r_gray;
  logic [N_IN-1:0]  r_pattern;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_start;
  logic             w_in_run;
  logic             w_term;
  logic             w_hold_last;
  logic             w_sample;
  logic [N_IN:0]    w_idx_nxt;
  logic [N_IN-1:0]  w_pat_nxt;
  logic [SIG_W-1:0] w_resp;
  logic [SIG_W-1:0] w_sig;

  // Abort masks Start, so Start+Abort in IDLE/DONE leaves the FSM where it is.
  assign w_start     = (r_state != ST_RUN) && Start && !Abort;
  assign w_in_run    = (r_state == ST_RUN);
  // idx has one spare bit: idx == 2^N_IN marks the cycle after the last sample.
  assign w_term      = r_idx[N_IN];
  assign w_hold_last = (r_hold == HOLD_LAST);
  assign w_sample    = w_in_run && !Abort && !w_term && w_hold_last;
  assign w_idx_nxt   = r_idx + (N_IN+1)'(1);
  assign w_pat_nxt   = r_gray ? N_IN'(bin2gray(HELPER_W'(w_idx_nxt[N_IN-1:0])))
                              : w_idx_nxt[N_IN-1:0];
  assign w_resp      = SIG_W'(CutResp);

  bist_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .load  (w_start),
    .seed  (SEED),
    .en    (w_sample),
    .resp  (w_resp),
    .sig   (w_sig)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_hold    <= '0;
      r_gray    <= 1'b0;
      r_pattern <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state   <= ST_RUN;
            r_idx     <= '0;
            r_hold    <= '0;
            r_gray    <= GrayMode;
            r_pattern <= '0;  // index 0 is pattern 0 in either order
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (Abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (w_term) begin
            // Final MISR step landed on the previous edge, so w_sig is final here.
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_sig == GOLDEN);
          end else if (w_hold_last) begin
            r_hold <= '0;
            r_idx  <= w_idx_nxt;
            // Keep the last pattern on the CUT once the sequence is exhausted.
            if (!w_idx_nxt[N_IN]) begin
              r_pattern <= w_pat_nxt;
            end
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Pattern   = r_pattern;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Pass      = r_pass;
  assign Signature = w_sig;

endmodule

// File: tb/tb_exhaustive_bist_ctrl.sv
// tb/tb_exhaustive_bist_ctrl.sv - self-checking bench for exhaustive_bist_ctrl
module tb_exhaustive_bist_ctrl;

  typedef struct {
    int         sel;   // 0: HOLD=1 instance, 1: HOLD=3 instance
    logic       gray;
    logic [3:0] sig;
    logic       pass;
    int         lat;   // edges from the Start edge to Done
    int         rk;    // cycle at which a spurious Start is pulsed, -1 for none
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start0, abort0, gray0, busy0, done0, pass0;
  logic [1:0] pat0;
  logic [3:0] sig0;
  logic       start1, abort1, gray1, busy1, done1, pass1;
  logic [1:0] pat1;
  logic [3:0] sig1;
  logic        start2, abort2, gray2, busy2, done2, pass2;
  logic [4:0]  pat2;
  logic [15:0] sig2;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] q_exp[$];
  logic [1:0] bin_ord[4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] gray_ord[4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  vec_t vecs[4];

  exhaustive_bist_ctrl #(
    .N_IN(2), .N_OUT(2), .SIG_W(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h3), .HOLD(1)
  ) u_dut0 (
    .Clk(clk), .Rst_n(rst_n), .Start(start0), .Abort(abort0), .GrayMode(gray0),
    .Pattern(pat0), .CutResp(pat0), .Busy(busy0), .Done(done0), .Pass(pass0), .Signature(sig0)
  );

  exhaustive_bist_ctrl #(
    .N_IN(2), .N_OUT(2), .SIG_W(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h3), .HOLD(3)
  ) u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .Start(start1), .Abort(abort1), .GrayMode(gray1),
    .Pattern(pat1), .CutResp(pat1), .Busy(busy1), .Done(done1), .Pass(pass1), .Signature(sig1)
  );

  exhaustive_bist_ctrl u_dut2 (
    .Clk(clk), .Rst_n(rst_n), .Start(start2), .Abort(abort2), .GrayMode(gray2),
    .Pattern(pat2), .CutResp(pat2[1:0]), .Busy(busy2), .Done(done2), .Pass(pass2), .Signature(sig2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_pat(int sel);
    return (sel == 0) ? 32'(pat0) : 32'(pat1);
  endfunction
  function automatic logic get_busy(int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_done(int sel);
    return (sel == 0) ? done0 : done1;
  endfunction
  function automatic logic get_pass(int sel);
    return (sel == 0) ? pass0 : pass1;
  endfunction
  function automatic logic [31:0] get_sig(int sel);
    return (sel == 0) ? 32'(sig0) : 32'(sig1);
  endfunction

  task automatic drive_start(int sel, logic s, logic g);
    if (sel == 0) begin start0 = s; gray0 = g; end
    else          begin start1 = s; gray1 = g; end
  endtask

  task automatic run_vec(input vec_t v);
    int         hold;
    logic [4:0] cur;
    logic [1:0] last;
    hold = (v.sel == 0) ? 1 : 3;
    cur  = '0;
    for (int i = 0; i < 4; i++) q_exp.push_back(5'(v.gray ? gray_ord[i] : bin_ord[i]));
    last = v.gray ? gray_ord[3] : bin_ord[3];
    @(negedge clk);
    drive_start(v.sel, 1'b1, v.gray);
    for (int k = 0; k <= v.lat; k++) begin
      @(negedge clk);
      if (k < 4 * hold) begin
        if (k % hold == 0) begin
          if (q_exp.size() == 0) chk("scoreboard_empty", 32'(q_exp.size()), 32'd1);
          else cur = q_exp.pop_front();
        end
        chk("pattern", get_pat(v.sel), 32'(cur));
      end
      if (k == 0) begin
        chk("busy_first", 32'(get_busy(v.sel)), 32'd1);
        chk("done_cleared", 32'(get_done(v.sel)), 32'd0);
      end
      if (k == v.lat - 1) begin
        chk("done_early", 32'(get_done(v.sel)), 32'd0);
        chk("busy_before_done", 32'(get_busy(v.sel)), 32'd1);
      end
      if (k == v.lat) begin
        chk("done", 32'(get_done(v.sel)), 32'd1);
        chk("busy_after", 32'(get_busy(v.sel)), 32'd0);
        chk("signature", get_sig(v.sel), 32'(v.sig));
        chk("pass", 32'(get_pass(v.sel)), 32'(v.pass));
        chk("pattern_held", get_pat(v.sel), 32'(last));
      end
      // Drives for the following edge
      if (k == 0) drive_start(v.sel, 1'b0, v.gray);
      if (k == v.rk) drive_start(v.sel, 1'b1, ~v.gray);
      if (k == v.rk + 1) drive_start(v.sel, 1'b0, v.gray);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] m;
    logic [31:0] seen;
    logic [4:0]  e;

    vecs[0] = '{sel: 0, gray: 1'b0, sig: 4'h3, pass: 1'b1, lat: 5,  rk: -1};
    vecs[1] = '{sel: 0, gray: 1'b1, sig: 4'h0, pass: 1'b0, lat: 5,  rk: -1};
    vecs[2] = '{sel: 1, gray: 1'b0, sig: 4'h3, pass: 1'b1, lat: 13, rk: -1};
    vecs[3] = '{sel: 0, gray: 1'b0, sig: 4'h3, pass: 1'b1, lat: 5,  rk: 2};

    rst_n = 1'b0;
    {start0, abort0, gray0} = '0;
    {start1, abort1, gray1} = '0;
    {start2, abort2, gray2} = '0;
    repeat (3) @(negedge clk);
    chk("rst_pattern", 32'(pat0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_sig", 32'(sig0), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Abort on the second RUN cycle
    @(negedge clk); start0 = 1'b1; gray0 = 1'b0;
    @(negedge clk); start0 = 1'b0;
    chk("abort_p0", 32'(pat0), 32'd0);
    @(negedge clk); abort0 = 1'b1;
    @(negedge clk); abort0 = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_sig", 32'(sig0), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_sig_frozen", 32'(sig0), 32'd0);
    chk("abort_done_stays", 32'(done0), 32'd0);
    // Start and Abort together in IDLE
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
    chk("start_abort_idle", 32'(busy0), 32'd0);
    repeat (2) @(negedge clk);
    chk("start_abort_idle2", 32'(busy0), 32'd0);
    run_vec(vecs[0]);

    // Reset while idx=2
    @(negedge clk); start0 = 1'b1; gray0 = 1'b0;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_pattern", 32'(pat0), 32'd2);
    chk("mid_sig", 32'(sig0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pattern", 32'(pat0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_sig", 32'(sig0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    chk("arst_pass", 32'(pass0), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_partial_done", 32'(done0), 32'd0);

    // Default parameters: 32 patterns, each exactly once
    for (int i = 0; i < 32; i++) q_exp.push_back(5'(i));
    m = 16'h0000;
    seen = '0;
    e = '0;
    @(negedge clk); start2 = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      if (k == 0) start2 = 1'b0;
      if (k < 32) begin
        if (q_exp.size() == 0) chk("def_scoreboard_empty", 32'(q_exp.size()), 32'd1);
        else e = q_exp.pop_front();
        chk("def_pattern", 32'(pat2), 32'(e));
        chk("def_unique", 32'(seen[pat2]), 32'd0);
        seen[pat2] = 1'b1;
        m = {m[14:0], 1'b0} ^ (m[15] ? 16'h002D : 16'h0000) ^ {14'b0, e[1:0]};
      end
      if (k == 32) chk("def_done_early", 32'(done2), 32'd0);
      if (k == 33) begin
        chk("def_done", 32'(done2), 32'd1);
        chk("def_sig", 32'(sig2), 32'(m));
        chk("def_pass", 32'(pass2), 32'(m == 16'h0000));
      end
    end
    chk("def_visited", 32'($countones(seen)), 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
